// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational decode into a registered 2-entry skid buffer.
// Optional custom-0 GEMM command decode is enabled by defining RV_DECODE_GEMM_EN.
module rv_decode_stage #(
  parameter int unsigned PC_W           = 32,
  parameter int unsigned CNT_W          = 16,
  parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [3:0]       alu_con,
  output logic             reg_wr,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_mux_1,
  output logic             alu_mux_2,
  output logic             pc_jump_mux,
  output logic [1:0]       wr_bck_mux,
  output logic [2:0]       sign_extend,
  output logic [2:0]       func3_to_mem,
  output logic [2:0]       branch_type,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [31:0]      imm,
  output logic             illegal,
`ifdef RV_DECODE_GEMM_EN
  output logic             gemm_cmd,
`endif
  output logic [CNT_W-1:0] decode_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef RV_DECODE_GEMM_EN
  localparam logic [6:0] OP_GEMM   = 7'b0001011;
`endif

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      alu_con;
    logic            reg_wr;
    logic            mem_read;
    logic            mem_write;
    logic            alu_mux_1;
    logic            alu_mux_2;
    logic            pc_jump_mux;
    logic [1:0]      wr_bck_mux;
    logic [2:0]      sign_extend;
    logic [2:0]      func3_to_mem;
    logic [2:0]      branch_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            illegal;
`ifdef RV_DECODE_GEMM_EN
    logic            gemm_cmd;
`endif
  } entry_t;

  entry_t           dec;
  entry_t           ent_q [2];
  entry_t           ent_d [2];
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] decode_cnt_q, decode_cnt_d;
  logic             push, pop, wr_idx;

  logic [2:0] f3;
  assign f3 = in_instr[14:12];

  // Instruction decode; LUI/AUIPC/JAL/JALR take the immediate on ALU B.
  always_comb begin
    dec              = '0;
    dec.pc           = in_pc;
    dec.func3_to_mem = f3;
    dec.branch_type  = 3'b010;
    dec.rd           = in_instr[11:7];
    dec.rs1          = in_instr[19:15];
    dec.rs2          = in_instr[24:20];
    case (in_instr[6:0])
      OP_R: begin
        dec.alu_con = {in_instr[30], f3};
        dec.reg_wr  = 1'b1;
      end
      OP_IALU: begin
        dec.alu_con   = {(f3 == 3'b101) ? in_instr[30] : 1'b0, f3};
        dec.reg_wr    = 1'b1;
        dec.alu_mux_2 = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_wr     = 1'b1;
        dec.mem_read   = 1'b1;
        dec.wr_bck_mux = 2'd1;
        dec.alu_mux_2  = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write   = 1'b1;
        dec.sign_extend = 3'd1;
        dec.alu_mux_2   = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch_type = f3;
        dec.alu_mux_1   = 1'b1;
        dec.alu_mux_2   = 1'b1;
        dec.sign_extend = 3'd2;
        dec.illegal     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI: begin
        dec.alu_con     = 4'b1111;
        dec.reg_wr      = 1'b1;
        dec.alu_mux_2   = 1'b1;
        dec.sign_extend = 3'd3;
      end
      OP_AUIPC: begin
        dec.reg_wr      = 1'b1;
        dec.alu_mux_1   = 1'b1;
        dec.alu_mux_2   = 1'b1;
        dec.sign_extend = 3'd3;
      end
      OP_JAL: begin
        dec.reg_wr      = 1'b1;
        dec.pc_jump_mux = 1'b1;
        dec.alu_mux_1   = 1'b1;
        dec.alu_mux_2   = 1'b1;
        dec.wr_bck_mux  = 2'd2;
        dec.sign_extend = 3'd4;
      end
      OP_JALR: begin
        dec.reg_wr      = 1'b1;
        dec.pc_jump_mux = 1'b1;
        dec.alu_mux_2   = 1'b1;
        dec.wr_bck_mux  = 2'd2;
        dec.illegal     = (f3 != 3'b000);
      end
`ifdef RV_DECODE_GEMM_EN
      OP_GEMM: dec.gemm_cmd = 1'b1;
`endif
      default: dec.illegal = 1'b1;
    endcase
    case (dec.sign_extend)
      3'd1:    dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'd2:    dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      3'd3:    dec.imm = {in_instr[31:12], 12'd0};
      3'd4:    dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
    endcase
    if (ILLEGAL_AS_NOP && dec.illegal) begin
      dec.reg_wr    = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
  end

  assign push = in_valid & in_ready_q & ~flush;
  assign pop  = out_valid_q & out_ready;

  // Shift-register buffer: head at entry 0, new word lands behind the survivors.
  always_comb begin
    ent_d        = ent_q;
    cnt_d        = cnt_q;
    wr_idx       = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
    decode_cnt_d = decode_cnt_q + CNT_W'(pop);
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) ent_d[0] = ent_q[1];
      if (push) ent_d[wr_idx] = dec;
      case ({push, pop})
        2'b10:   cnt_d = 2'(cnt_q + 2'd1);
        2'b01:   cnt_d = 2'(cnt_q - 2'd1);
        default: cnt_d = cnt_q;
      endcase
    end
    in_ready_d  = (cnt_d != 2'd2);
    out_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ent_q[i]             <= '0;
        ent_q[i].branch_type <= 3'b010;
      end
      cnt_q        <= 2'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      decode_cnt_q <= '0;
    end else begin
      ent_q        <= ent_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      decode_cnt_q <= decode_cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign decode_cnt   = decode_cnt_q;
  assign out_pc       = ent_q[0].pc;
  assign alu_con      = ent_q[0].alu_con;
  assign reg_wr       = ent_q[0].reg_wr;
  assign mem_read     = ent_q[0].mem_read;
  assign mem_write    = ent_q[0].mem_write;
  assign alu_mux_1    = ent_q[0].alu_mux_1;
  assign alu_mux_2    = ent_q[0].alu_mux_2;
  assign pc_jump_mux  = ent_q[0].pc_jump_mux;
  assign wr_bck_mux   = ent_q[0].wr_bck_mux;
  assign sign_extend  = ent_q[0].sign_extend;
  assign func3_to_mem = ent_q[0].func3_to_mem;
  assign branch_type  = ent_q[0].branch_type;
  assign rd           = ent_q[0].rd;
  assign rs1          = ent_q[0].rs1;
  assign rs2          = ent_q[0].rs2;
  assign imm          = ent_q[0].imm;
  assign illegal      = ent_q[0].illegal;
`ifdef RV_DECODE_GEMM_EN
  assign gemm_cmd     = ent_q[0].gemm_cmd;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed words, expected bundles queued at issue.
module tb_rv_decode_stage;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef logic [127:0] bv_t;

  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [3:0] alu_con;
  logic reg_wr, mem_read, mem_write, alu_mux_1, alu_mux_2, pc_jump_mux, illegal, gemm;
  logic [1:0] wr_bck_mux;
  logic [2:0] sign_extend, func3_to_mem, branch_type;
  logic [4:0] rd, rs1, rs2;
  logic [CNT_W-1:0] decode_cnt;

  rv_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_con(alu_con), .reg_wr(reg_wr), .mem_read(mem_read), .mem_write(mem_write),
    .alu_mux_1(alu_mux_1), .alu_mux_2(alu_mux_2), .pc_jump_mux(pc_jump_mux),
    .wr_bck_mux(wr_bck_mux), .sign_extend(sign_extend), .func3_to_mem(func3_to_mem),
    .branch_type(branch_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .illegal(illegal),
`ifdef RV_DECODE_GEMM_EN
    .gemm_cmd(gemm),
`endif
    .decode_cnt(decode_cnt)
  );
`ifndef RV_DECODE_GEMM_EN
  assign gemm = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bv_t sb[$];
  string dq_name[$];
  bv_t dq_act[$];
  bv_t dq_exp[$];

  function automatic bv_t pk(input logic [31:0] pc, input logic [3:0] alu,
                             input logic rw, input logic mr, input logic mw,
                             input logic m1, input logic m2, input logic j,
                             input logic [1:0] wb, input logic [2:0] se,
                             input logic [2:0] f3, input logic [2:0] bt,
                             input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [31:0] im, input logic ill, input logic g);
    return {26'd0, pc, alu, rw, mr, mw, m1, m2, j, wb, se, f3, bt, d, s1, s2, im, ill, g};
  endfunction

  task automatic chk(input string nm, input bv_t act, input bv_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: evaluates queued direct checks, then scores every output handshake.
  always @(negedge clk) begin
    while (dq_name.size() > 0) chk(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got pc %h with empty scoreboard", out_pc);
      end else begin
        chk("entry", pk(out_pc, alu_con, reg_wr, mem_read, mem_write, alu_mux_1, alu_mux_2,
                        pc_jump_mux, wr_bck_mux, sign_extend, func3_to_mem, branch_type,
                        rd, rs1, rs2, imm, illegal, gemm), sb.pop_front());
      end
    end
  end

  task automatic req(input string nm, input bv_t a, input bv_t e);
    dq_name.push_back(nm);
    dq_act.push_back(a);
    dq_exp.push_back(e);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input bit exp_en,
                      input bv_t e);
    int budget = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      req("push_timeout", bv_t'(in_ready), 1);
    end else begin
      if (exp_en) sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    req("drain", bv_t'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  bv_t v1, v2, v3, v4, v5, v6, v7, v8, v9;

  initial begin
    v1 = pk(32'h100, 4'b0000, 1,0,0,0,0,0, 2'd0, 3'd0, 3'b000, 3'b010, 5'd4,  5'd2, 5'd3,  32'd3,  0, 0);
    v2 = pk(32'h104, 4'b0000, 1,0,0,0,1,0, 2'd0, 3'd0, 3'b000, 3'b010, 5'd12, 5'd4, 5'd14, 32'd14, 0, 0);
    v3 = pk(32'h108, 4'b0000, 0,0,1,0,1,0, 2'd0, 3'd1, 3'b010, 3'b010, 5'd0,  5'd4, 5'd0,  32'd0,  0, 0);
    v4 = pk(32'h10c, 4'b1111, 1,0,0,0,1,0, 2'd0, 3'd3, 3'b101, 3'b010, 5'd8,  5'd8, 5'd3,  32'h12345000, 0, 0);
    v5 = pk(32'h200, 4'b0000, 1,0,0,1,1,1, 2'd2, 3'd4, 3'b000, 3'b010, 5'd2,  5'd0, 5'd4,  32'd4,  0, 0);
    v6 = pk(32'h204, 4'b0000, 0,0,0,1,1,0, 2'd0, 3'd2, 3'b001, 3'b001, 5'd4,  5'd0, 5'd4,  32'd4,  0, 0);
    v7 = pk(32'h208, 4'b0000, 0,0,0,1,1,0, 2'd0, 3'd2, 3'b010, 3'b010, 5'd4,  5'd0, 5'd4,  32'd4,  1, 0);
    v8 = pk(32'h20c, 4'b0000, 0,0,0,0,0,0, 2'd0, 3'd0, 3'b000, 3'b010, 5'd0,  5'd0, 5'd0,  32'd0,  1, 0);
`ifdef RV_DECODE_GEMM_EN
    v9 = pk(32'h210, 4'b0000, 0,0,0,0,0,0, 2'd0, 3'd0, 3'b010, 3'b010, 5'd0,  5'd0, 5'd0,  32'd0,  0, 1);
`else
    v9 = pk(32'h210, 4'b0000, 0,0,0,0,0,0, 2'd0, 3'd0, 3'b010, 3'b010, 5'd0,  5'd0, 5'd0,  32'd0,  1, 0);
`endif

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = '0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    req("rst_out_valid", bv_t'(out_valid), 0);
    req("rst_in_ready", bv_t'(in_ready), 1);
    req("rst_decode_cnt", bv_t'(decode_cnt), 0);
    req("rst_branch_type", bv_t'(branch_type), 3'b010);
    req("rst_reg_wr", bv_t'(reg_wr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single R-type through an always-ready sink
    out_ready = 1'b1;
    push(32'h00310233, 32'h100, 1, v1);
    drain();
    req("cnt_after_r", bv_t'(decode_cnt), 1);

    // Fill the buffer against a stalled sink, hold a third word, then release
    out_ready = 1'b0;
    push(32'h00e20613, 32'h104, 1, v2);
    push(32'h00022023, 32'h108, 1, v3);
    req("full_in_ready", bv_t'(in_ready), 0);
    in_valid = 1'b1; in_instr = 32'h12345437; in_pc = 32'h10c;
    repeat (2) begin @(posedge clk); #1; end
    req("held_in_ready", bv_t'(in_ready), 0);
    req("held_out_valid", bv_t'(out_valid), 1);
    req("held_head_rd", bv_t'(rd), 12);
    req("held_head_pc", bv_t'(out_pc), 32'h104);
    out_ready = 1'b1;
    push(32'h12345437, 32'h10c, 1, v4);
    drain();
    req("cnt_after_burst", bv_t'(decode_cnt), 4);

    // Jump, branch, illegal branch funct3, all-zero word, custom-0
    push(32'h0040016f, 32'h200, 1, v5);
    push(32'h00401263, 32'h204, 1, v6);
    push(32'h00402263, 32'h208, 1, v7);
    push(32'h00000000, 32'h20c, 1, v8);
    push(32'h0000200b, 32'h210, 1, v9);
    drain();
    req("cnt_after_mix", bv_t'(decode_cnt), 9);

    // Flush with two entries held plus a presented word
    out_ready = 1'b0;
    push(32'h00310233, 32'h300, 0, v1);
    push(32'h00e20613, 32'h304, 0, v1);
    in_valid = 1'b1; in_instr = 32'h00022023; in_pc = 32'h308; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    req("flush_out_valid", bv_t'(out_valid), 0);
    req("flush_in_ready", bv_t'(in_ready), 1);
    req("flush_cnt", bv_t'(decode_cnt), 9);
    // Flush with one held and an acceptable concurrent push: push must be dropped
    push(32'h00310233, 32'h310, 0, v1);
    in_valid = 1'b1; in_instr = 32'h00e20613; in_pc = 32'h314; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    req("flush2_out_valid", bv_t'(out_valid), 0);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    push(32'h12345437, 32'h10c, 1, v4);
    drain();
    req("cnt_after_flush", bv_t'(decode_cnt), 10);

    // Asynchronous reset while two entries are held
    out_ready = 1'b0;
    push(32'h00310233, 32'h400, 0, v1);
    push(32'h00e20613, 32'h404, 0, v1);
    #2 rst_n = 1'b0;
    #1;
    req("arst_out_valid", bv_t'(out_valid), 0);
    req("arst_in_ready", bv_t'(in_ready), 1);
    req("arst_decode_cnt", bv_t'(decode_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'h00401263, 32'h204, 1, v6);
    drain();
    req("cnt_after_arst", bv_t'(decode_cnt), 1);

    req("sb_empty", bv_t'(sb.size()), 0);
    @(negedge clk); @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, handshaked RV32I decode stage that replaces the purely combinational control decoder in the CPU.
- Accepts instruction words from fetch over a valid/ready interface and decodes them into the existing control-signal bundle, plus register indices, immediate and illegal flag.
- Presents the result one cycle later through a 2-entry skid buffer, so fetch and execute can stall independently.
- Sits between the fetch stage and the execute/GEMM dispatch stage.

Parameters:
- PC_W, 32, width of the PC carried alongside each instruction.
- CNT_W, 16, width of the retired-decode counter; wraps modulo 2^CNT_W.
- ILLEGAL_AS_NOP, 1: 1 = illegal words emit `illegal`=1 with all write/mem enables forced 0; 0 = illegal flag only.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all buffered entries.
- in_valid  input  1  fetch word valid.
- in_ready  output  1  stage can accept a word.
- in_instr  input  32  instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  execute accepts the entry.
- out_pc  output  PC_W  PC of the entry.
- alu_con  output  4  ALU operation.
- reg_wr  output  1  register write enable.
- mem_read  output  1  load.
- mem_write  output  1  store.
- alu_mux_1  output  1  ALU A select: 1 = PC, 0 = rs1.
- alu_mux_2  output  1  ALU B select: 1 = imm, 0 = rs2.
- pc_jump_mux  output  1  unconditional jump (JAL/JALR).
- wr_bck_mux  output  2  writeback select: 0 = ALU, 1 = memory, 2 = PC+4.
- sign_extend  output  3  immediate type: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- func3_to_mem  output  3  instr[14:12].
- branch_type  output  3  funct3 for BRANCH, 3'b010 (no branch) otherwise.
- rd, rs1, rs2  output  5 each  register indices.
- imm  output  32  sign-extended immediate per sign_extend.
- illegal  output  1  unsupported opcode/funct.
- decode_cnt  output  CNT_W  count of entries accepted by execute (out_valid & out_ready).

Behaviour:
- Reset (async, rst_n low): buffer empty; out_valid=0, in_ready=1, decode_cnt=0; all decoded outputs 0 except branch_type=3'b010.
- Decode is combinational on in_instr; the result plus in_pc is written into the buffer on in_valid & in_ready.
- Latency: one cycle from an accepted input to out_valid.
- Buffer holds 2 entries. Outputs always show the head entry.
  - in_ready = 1 when fewer than 2 entries are held. It is registered and carries no combinational path from out_ready.
  - Simultaneous push and pop: occupancy is unchanged and order is preserved.
- Outputs stay stable while out_valid & !out_ready.
- flush: occupancy goes to 0 the next cycle; an input presented in the flush cycle is discarded. decode_cnt is not changed by flush.
- Opcode decode:
  - R 0110011: alu_con={instr[30],funct3}, reg_wr=1.
  - I-ALU 0010011: alu_con={funct3==101 ? instr[30] : 0, funct3}, alu_mux_2=1, sign_extend=0.
  - LOAD 0000011: mem_read=1, wr_bck_mux=1, alu_mux_2=1, alu_con=0000.
  - STORE 0100011: mem_write=1, reg_wr=0, sign_extend=1, alu_mux_2=1.
  - BRANCH 1100011: branch_type=funct3, alu_mux_1=1, alu_mux_2=1, sign_extend=2. funct3 010 or 011 is illegal.
  - LUI 0110111: alu_con=1111 (pass B), sign_extend=3.
  - AUIPC 0010111: alu_mux_1=1, sign_extend=3.
  - JAL 1101111: pc_jump_mux=1, alu_mux_1=1, wr_bck_mux=2, sign_extend=4.
  - JALR 1100111 (funct3 must be 000): pc_jump_mux=1, wr_bck_mux=2, sign_extend=0.
  - Any other opcode, or instr[1:0]!=11: illegal=1.
- decode_cnt increments on out_valid & out_ready and wraps to 0 after all ones.

Optional Feature:
- Macro RV_DECODE_GEMM_EN.
- Defined: opcode 0001011 (custom-0) decodes as a GEMM command. It raises the extra output port gemm_cmd=1, with reg_wr=0 and illegal=0; funct3 is carried on func3_to_mem.
- Undefined: port absent; custom-0 is illegal.

Test Plan:
- Reset mid-stream with 2 entries held -> out_valid=0, in_ready=1, decode_cnt=0 immediately, without waiting for a clock edge.
- Push 0x00310233, out_ready=1 -> next cycle: alu_con=0000, reg_wr=1, rd=4, rs1=2, rs2=3, wr_bck_mux=0; decode_cnt=1 after the pop.
- Push 0x00e20613, 0x00022023, 0x12345437 with out_ready=0 -> in_ready falls after 2 accepts and the third is held. Release -> in order:
  - imm=14, rd=12;
  - mem_write=1, sign_extend=1, imm=0;
  - imm=0x12345000, alu_con=1111, rd=8.
- Push 0x0040016f -> pc_jump_mux=1, wr_bck_mux=2, sign_extend=4, imm=4, rd=2. Push 0x00401263 -> branch_type=001, imm=4.
- Push 0x00000000 -> illegal=1, reg_wr=mem_read=mem_write=0. Push 0x0000200b -> illegal=1 without RV_DECODE_GEMM_EN; gemm_cmd=1, illegal=0 with it.
- Assert flush with 2 entries held plus a concurrent push -> out_valid=0 next cycle, decode_cnt unchanged.
